// File: rtl/dct_pkg.sv
// dct_pkg: widths, cosine constants and output rounding for dct8x8_stream.
// Level shift of input pixels is built in when DCT_LEVEL_SHIFT_EN is defined.
package dct_pkg;

  localparam int DATA_W     = 8;
  localparam int OUT_W      = 12;
  localparam int COEF_FRAC  = 12;
  localparam int LATENCY    = 147;
  localparam int BLOCK_SIZE = 8;
  localparam int BLOCK_PIX  = 64;

  // Signed pixel, cosine constant, row result, column result.
  localparam int PIX_W    = DATA_W + 1;
  localparam int CW       = COEF_FRAC + 1;
  localparam int ROW_W    = PIX_W + CW + 3;
  localparam int COL_W    = ROW_W + CW + 3;
  localparam int ACC_FRAC = 2 * COEF_FRAC;

  // Registers behind the column result register.
  localparam int DLY_N = LATENCY - BLOCK_PIX;

  typedef logic signed [CW-1:0] coef_t;

  localparam logic [COL_W-1:0] HALF =
    COL_W'(1) << (ACC_FRAC - 1);

  // C(u)/2 * cos((2x+1)u*pi/16) in COEF_FRAC fixed point.
  function automatic coef_t dct_coef(
    input int u,
    input int x
  );
    int m;
    int mag;
    bit neg;
    if (u == 0) return coef_t'(1448);
    m = ((2 * x + 1) * u) % 32;
    if (m > 16) m = 32 - m;
    neg = (m > 8);
    if (neg) m = 16 - m;
    case (m)
      1:       mag = 2009;
      2:       mag = 1892;
      3:       mag = 1703;
      4:       mag = 1448;
      5:       mag = 1138;
      6:       mag = 784;
      7:       mag = 400;
      default: mag = 0;
    endcase
    return coef_t'(neg ? -mag : mag);
  endfunction

  // Drop ACC_FRAC bits, round half away from zero,
  // clamp to the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0]
    round_sat(input logic signed [COL_W-1:0] v);
    logic [COL_W-1:0] mag;
    logic [COL_W-1:0] q;
    mag = v[COL_W-1] ? COL_W'(-v) : COL_W'(v);
    q   = (mag + HALF) >> ACC_FRAC;
    if (!v[COL_W-1])
      return (q > COL_W'(2047)) ?
        OUT_W'(2047) : OUT_W'(q);
    return (q > COL_W'(2048)) ?
      OUT_W'(-2048) : OUT_W'(-q);
  endfunction

endpackage

// File: rtl/dct8x8_stream_if.sv
// dct8x8_stream_if: enable, pixel in, coefficient out.
// master drives enb/data_in; slave (the DCT) drives data_out.
interface dct8x8_stream_if;
  import dct_pkg::*;

  logic                    enb;
  logic [DATA_W-1:0]       data_in;
  logic signed [OUT_W-1:0] data_out;

  modport master (
    output enb,
    output data_in,
    input  data_out
  );

  modport slave (
    input  enb,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/dct1d_8pt.sv
// dct1d_8pt: combinational 8-point DCT-II, y(u) = sum K(u,i) x(i).
// Ports: x[8] signed IN_W in, y[8] signed Y_W out (COEF_FRAC more frac bits).
module dct1d_8pt
  import dct_pkg::*;
#(
  parameter int IN_W = PIX_W,
  parameter int Y_W  = IN_W + CW + 3
) (
  input  logic signed [IN_W-1:0] x [BLOCK_SIZE],
  output logic signed [Y_W-1:0]  y [BLOCK_SIZE]
);

  logic signed [Y_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int u = 0; u < BLOCK_SIZE; u++) begin
      acc = '0;
      for (int i = 0; i < BLOCK_SIZE; i++)
        acc = acc + Y_W'(x[i]) *
                    Y_W'(dct_coef(u, i));
      y[u] = acc;
    end
  end

endmodule

// File: rtl/dct8x8_stream.sv
// dct8x8_stream: streaming 8x8 forward DCT, one pixel in / one coeff out.
// Ports: clk, rst (sync, high), bus (slave: enb, data_in, data_out).
// DCT_LEVEL_SHIFT_EN subtracts 128 from every pixel.
module dct8x8_stream
  import dct_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  dct8x8_stream_if.slave bus
);

  typedef logic signed [ROW_W-1:0] row_t;
  typedef logic signed [OUT_W-1:0] out_t;

  logic [5:0] pcnt_q, pcnt_d;
  logic       bank_q, bank_d;

  logic signed [PIX_W-1:0] row_sr_q [BLOCK_SIZE-1];
  logic signed [PIX_W-1:0] row_sr_d [BLOCK_SIZE-1];

  row_t tbuf_q [2][BLOCK_PIX];
  row_t tbuf_d [2][BLOCK_PIX];

  out_t col_q, col_d;
  out_t dly_q [DLY_N];
  out_t dly_d [DLY_N];

  logic signed [PIX_W-1:0] pix_s;
  logic signed [PIX_W-1:0] row_x [BLOCK_SIZE];
  row_t                    row_y [BLOCK_SIZE];
  row_t                    col_x [BLOCK_SIZE];
  logic signed [COL_W-1:0] col_y [BLOCK_SIZE];

  always_comb begin
`ifdef DCT_LEVEL_SHIFT_EN
    pix_s = PIX_W'({1'b0, bus.data_in}) -
            PIX_W'(128);
`else
    pix_s = PIX_W'({1'b0, bus.data_in});
`endif
  end

  // Row vector: 7 buffered pixels plus the one
  // arriving now, so a row is complete on col 7.
  always_comb begin
    for (int i = 0; i < BLOCK_SIZE - 1; i++)
      row_x[i] = row_sr_q[i];
    row_x[BLOCK_SIZE-1] = pix_s;
  end

  dct1d_8pt #(.IN_W(PIX_W)) u_row (
    .x (row_x),
    .y (row_y)
  );

  // The bank not being written holds the previous
  // block; walk it column v, select output u.
  always_comb begin
    for (int r = 0; r < BLOCK_SIZE; r++)
      col_x[r] = tbuf_q[!bank_q]
                       [{3'(r), pcnt_q[2:0]}];
  end

  dct1d_8pt #(.IN_W(ROW_W)) u_col (
    .x (col_x),
    .y (col_y)
  );

  always_comb begin
    pcnt_d = pcnt_q + 6'd1;
    bank_d = bank_q ^ (pcnt_q == 6'd63);

    for (int i = 0; i < BLOCK_SIZE - 2; i++)
      row_sr_d[i] = row_sr_q[i+1];
    row_sr_d[BLOCK_SIZE-2] = pix_s;

    tbuf_d = tbuf_q;
    if (pcnt_q[2:0] == 3'd7)
      for (int i = 0; i < BLOCK_SIZE; i++)
        tbuf_d[bank_q][{pcnt_q[5:3], 3'(i)}] =
          row_y[i];

    col_d = round_sat(col_y[pcnt_q[5:3]]);

    dly_d[0] = col_q;
    for (int i = 1; i < DLY_N; i++)
      dly_d[i] = dly_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q   <= '0;
      bank_q   <= 1'b0;
      row_sr_q <= '{default: '0};
      tbuf_q   <= '{default: '{default: '0}};
      col_q    <= '0;
      dly_q    <= '{default: '0};
    end else if (bus.enb) begin
      pcnt_q   <= pcnt_d;
      bank_q   <= bank_d;
      row_sr_q <= row_sr_d;
      tbuf_q   <= tbuf_d;
      col_q    <= col_d;
      dly_q    <= dly_d;
    end
  end

  assign bus.data_out = dly_q[DLY_N-1];

endmodule

// File: tb/tb_dct8x8_stream.sv
// tb_dct8x8_stream: random/directed blocks vs a real-valued 2D DCT model.
// Expectations follow DCT_LEVEL_SHIFT_EN the same way the design does.
module tb_dct8x8_stream;
  import dct_pkg::*;

`ifdef DCT_LEVEL_SHIFT_EN
  localparam int SHIFT = 128;
`else
  localparam int SHIFT = 0;
`endif
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst;

  dct8x8_stream_if io ();

  dct8x8_stream dut (
    .clk (clk),
    .rst (rst),
    .bus (io.slave)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  nen;
  int  prev;
  int  exp_q [$];
  int  blk [$];
  real ct [8][8];

  task automatic check(
    input string tag,
    input int    got,
    input int    want,
    input int    tol
  );
    n_cmp++;
    if (got > want + tol || got < want - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d) t=%0t",
               tag, got, want, tol, $time);
    end
  endtask

  // Direct double sum over the block, rounded half
  // away from zero and clamped to 12-bit signed.
  function automatic int ref_coef(int u, int v);
    real s;
    real r;
    int  q;
    s = 0.0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        s += real'(blk[8*y+x] - SHIFT) *
             ct[u][y] * ct[v][x];
    r = (s >= 0.0) ? $floor(s + 0.5) :
                     -$floor(-s + 0.5);
    q = $rtoi(r);
    if (q > 2047)  q = 2047;
    if (q < -2048) q = -2048;
    return q;
  endfunction

  task automatic push_pixel(input int px);
    blk.push_back(px);
    if (blk.size() == BLOCK_PIX) begin
      for (int u = 0; u < 8; u++)
        for (int v = 0; v < 8; v++)
          exp_q.push_back(ref_coef(u, v));
      blk.delete();
    end
  endtask

  task automatic step(input bit e, input int px);
    int dout;
    io.enb     = e;
    io.data_in = 8'(px);
    @(posedge clk);
    #1;
    dout = int'(io.data_out);
    if (e) begin
      nen++;
      push_pixel(px);
      if (nen > LATENCY) begin
        if (exp_q.size() == 0)
          check("underrun", exp_q.size(), 1, 0);
        else
          check("coef", dout, exp_q.pop_front(), 1);
      end else begin
        check("pre", dout, 0, 0);
      end
    end else begin
      check("hold", dout, prev, 0);
    end
    prev = dout;
  endtask

  task automatic feed(input int px, input bit tog);
    bit e;
    int tries;
    tries = 0;
    do begin
      e = (tog && tries < 16) ?
          1'($urandom_range(0, 1)) : 1'b1;
      tries++;
      step(e, e ? px : int'($urandom_range(0, 255)));
    end while (!e);
  endtask

  function automatic int pix_of(
    input int kind,
    input int c,
    input int i
  );
    case (kind)
      0:       return c;
      1:       return (i == 0) ? 255 : 128;
      3:       return (((i >> 3) + i) & 1) ? 255 : 0;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic feed_block(
    input int kind,
    input int c,
    input bit tog
  );
    for (int i = 0; i < BLOCK_PIX; i++)
      feed(pix_of(kind, c, i), tog);
  endtask

  task automatic do_reset();
    io.enb     = 1'b1;
    io.data_in = 8'($urandom);
    rst        = 1'b1;
    @(posedge clk);
    #1;
    check("reset", int'(io.data_out), 0, 0);
    rst  = 1'b0;
    nen  = 0;
    prev = 0;
    exp_q.delete();
    blk.delete();
  endtask

  initial begin
    for (int u = 0; u < 8; u++)
      for (int i = 0; i < 8; i++)
        ct[u][i] = ((u == 0) ? 0.5 / $sqrt(2.0) : 0.5) *
                   $cos(real'((2 * i + 1) * u) * PI / 16.0);

    rst        = 1'b1;
    io.enb     = 1'b0;
    io.data_in = '0;
    nen        = 0;
    prev       = 0;
    repeat (3) @(posedge clk);
    #1;

    // Continuous stream: directed blocks then random.
    do_reset();
    feed_block(0, 255, 1'b0);
    feed_block(0, 128, 1'b0);
    feed_block(0, 0, 1'b0);
    feed_block(1, 0, 1'b0);
    feed_block(3, 0, 1'b0);
    repeat (150) feed_block(2, 0, 1'b0);
    repeat (3) feed_block(2, 0, 1'b0);

    // Enable toggling; holds are checked on idle edges.
    do_reset();
    feed_block(0, 255, 1'b1);
    repeat (100) feed_block(2, 0, 1'b1);
    repeat (3) feed_block(2, 0, 1'b1);

    // Reset after pixel 30 of a block, then restart.
    for (int i = 0; i < 31; i++)
      feed(int'($urandom_range(0, 255)), 1'b0);
    do_reset();
    feed_block(2, 0, 1'b0);
    feed_block(1, 0, 1'b0);
    feed_block(0, 0, 1'b0);
    repeat (3) feed_block(2, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
